// File: rtl/register_writeback_controller.sv
// register_writeback_controller
//   Write-back sequencer for the 8-bit core. It accepts one decoded instruction
//   at a time and selects the register-file write source (ALU, MOV or load
//   data). A LDUR runs a request/acknowledge read with data memory before its
//   single write. instr_ready back-pressures decode while an instruction is busy.
//
//   Optional feature: define WB_MEM_TIMEOUT_EN to abort a load that waits
//   MEM_TIMEOUT_CYCLES cycles without mem_ack. The abort is reported with a
//   one-cycle mem_timeout pulse.

package opcode_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0,
      OP_ADDI = 4'h1,
      OP_SUB  = 4'h2,
      OP_SUBI = 4'h3,
      OP_AND  = 4'h4,
      OP_OR   = 4'h5,
      OP_XOR  = 4'h6,
      OP_NOT  = 4'h7,
      OP_LSL  = 4'h8,
      OP_LSR  = 4'h9,
      OP_MOV1 = 4'hA,
      OP_MOV2 = 4'hB,
      OP_LDUR = 4'hC,
      OP_STUR = 4'hD,
      OP_CBZ  = 4'hE
   } opcode_t;

   // Write-back source selected by an opcode.
   typedef enum logic [1:0] {
      WB_NONE,
      WB_ALU,
      WB_MOV,
      WB_LOAD
   } wb_class_t;

   // Map a raw opcode field to its write-back class. Encodings that are not
   // opcode_t members fall into the default and never write.
   function automatic wb_class_t classify(input logic [3:0] op);
      wb_class_t cls;
      case (op)
         OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_AND,
         OP_OR, OP_XOR, OP_NOT, OP_LSL, OP_LSR: cls = WB_ALU;
         OP_MOV1, OP_MOV2:                      cls = WB_MOV;
         OP_LDUR:                               cls = WB_LOAD;
         default:                               cls = WB_NONE;
      endcase
      return cls;
   endfunction

endpackage

module register_writeback_controller
   import opcode_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic [7:0] instruction,
   input  logic [7:0] alu_result,
   input  logic [7:0] mov_value,
   output logic       mem_req,
   input  logic       mem_ack,
   input  logic [7:0] mem_rdata,
   output logic       rf_we,
   output logic [1:0] rf_waddr,
   output logic [7:0] rf_wdata
`ifdef WB_MEM_TIMEOUT_EN
   ,
   output logic       mem_timeout
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WB,
      S_MEM_WAIT,
      S_MEM_WB
   } state_t;

   state_t    state;
   state_t    state_next;
   wb_class_t cls;
   logic      accept;
   logic [1:0] waddr_q;
   logic [7:0] wdata_q;

`ifdef WB_MEM_TIMEOUT_EN
   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT_CYCLES - 1);

   logic [7:0] wait_cnt;
   logic       timeout_hit;
   logic       mem_timeout_q;
`endif

   assign cls = classify(instruction[7:4]);

   // State register; synchronous reset abandons any in-flight instruction.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and Moore outputs.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned, which would infer a latch.
      state_next  = state;
      instr_ready = 1'b0;
      mem_req     = 1'b0;
      rf_we       = 1'b0;
      accept      = 1'b0;
`ifdef WB_MEM_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            instr_ready = 1'b1;
            accept      = instr_valid;
            if (instr_valid) begin
               case (cls)
                  WB_ALU, WB_MOV: state_next = S_WB;
                  WB_LOAD:        state_next = S_MEM_WAIT;
                  default:        state_next = S_IDLE;
               endcase
            end
         end
         S_WB: begin
            rf_we      = 1'b1;
            state_next = S_IDLE;
         end
         S_MEM_WAIT: begin
            mem_req = 1'b1;
            // An ack on the final allowed cycle still completes the load.
            if (mem_ack) begin
               state_next = S_MEM_WB;
            end
`ifdef WB_MEM_TIMEOUT_EN
            else if (wait_cnt == WAIT_LAST) begin
               timeout_hit = 1'b1;
               state_next  = S_IDLE;
            end
`endif
         end
         S_MEM_WB: begin
            rf_we      = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Write-port registers: source data and destination captured per class.
   always_ff @(posedge clk) begin
      // NOTE: these data registers are reset so rf_waddr/rf_wdata read 0
      // after reset, even though they matter only while rf_we is high.
      if (rst) begin
         waddr_q <= 2'd0;
         wdata_q <= 8'h00;
      end else if (accept) begin
         case (cls)
            WB_ALU: begin
               waddr_q <= instruction[3:2];
               wdata_q <= alu_result;
            end
            WB_MOV: begin
               waddr_q <= instruction[3:2];
               wdata_q <= mov_value;
            end
            WB_LOAD: begin
               waddr_q <= instruction[3:2];
            end
            default: begin
            end
         endcase
      end else if (state == S_MEM_WAIT && mem_ack) begin
         wdata_q <= mem_rdata;
      end
   end

   assign rf_waddr = waddr_q;
   assign rf_wdata = wdata_q;

`ifdef WB_MEM_TIMEOUT_EN
   // Wait counter: cleared on MEM_WAIT entry, counts ack-less MEM_WAIT cycles;
   // the abort pulse is registered so it appears in the first IDLE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt      <= 8'd0;
         mem_timeout_q <= 1'b0;
      end else begin
         mem_timeout_q <= timeout_hit;
         if (state != S_MEM_WAIT && state_next == S_MEM_WAIT) begin
            wait_cnt <= 8'd0;
         end else if (state == S_MEM_WAIT && !mem_ack) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
      end
   end

   assign mem_timeout = mem_timeout_q;

   logic unused_bits;
   assign unused_bits = ^instruction[1:0];
`else
   logic unused_bits;
   assign unused_bits = ^{instruction[1:0], 32'(MEM_TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_register_writeback_controller.sv
// Self-checking bench for register_writeback_controller.
// A transaction-level model (write due / load outstanding / cycles waited)
// predicts the outputs every cycle; directed sequences pin the model with
// hand-computed literal values, then a randomized phase stresses it.
// Timeout behaviour is exercised when WB_MEM_TIMEOUT_EN is defined.

module tb_register_writeback_controller;
   import opcode_pkg::*;

   localparam int unsigned LIMIT = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       instr_valid = 1'b0;
   logic [7:0] instruction = 8'h00;
   logic [7:0] alu_result = 8'h00;
   logic [7:0] mov_value = 8'h00;
   logic       mem_ack = 1'b0;
   logic [7:0] mem_rdata = 8'h00;
   logic       instr_ready;
   logic       mem_req;
   logic       rf_we;
   logic [1:0] rf_waddr;
   logic [7:0] rf_wdata;
`ifdef WB_MEM_TIMEOUT_EN
   logic       mem_timeout;
`endif

   register_writeback_controller #(.MEM_TIMEOUT_CYCLES(LIMIT)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instruction (instruction),
      .alu_result  (alu_result),
      .mov_value   (mov_value),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata)
`ifdef WB_MEM_TIMEOUT_EN
      ,
      .mem_timeout (mem_timeout)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int dut_writes = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] mk(input logic [3:0] op, input logic [1:0] rd);
      return {op, rd, 2'b00};
   endfunction

   // Instruction class from the opcode table: 1 ALU, 2 MOV, 3 load, 0 none.
   function automatic int op_kind(input logic [3:0] op);
      if (op inside {OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LSL, OP_LSR})
         return 1;
      if (op inside {OP_MOV1, OP_MOV2})
         return 2;
      if (op == OP_LDUR)
         return 3;
      return 0;
   endfunction

   // Behavioural model: what is outstanding right now.
   bit         m_write_due = 1'b0;
   bit         m_loading   = 1'b0;
   bit         m_timeout   = 1'b0;
   int         m_waited    = 0;
   logic [1:0] m_addr      = 2'd0;
   logic [7:0] m_data      = 8'h00;

   always @(posedge clk) begin
      if (rst) begin
         m_write_due = 1'b0;
         m_loading   = 1'b0;
         m_timeout   = 1'b0;
         m_addr      = 2'd0;
         m_data      = 8'h00;
      end else begin
         m_timeout = 1'b0;
         if (m_write_due) begin
            m_write_due = 1'b0;
         end else if (m_loading) begin
            if (mem_ack) begin
               m_data      = mem_rdata;
               m_loading   = 1'b0;
               m_write_due = 1'b1;
            end else begin
               m_waited++;
`ifdef WB_MEM_TIMEOUT_EN
               if (m_waited == LIMIT) begin
                  m_loading = 1'b0;
                  m_timeout = 1'b1;
               end
`endif
            end
         end else if (instr_valid) begin
            case (op_kind(instruction[7:4]))
               1: begin m_addr = instruction[3:2]; m_data = alu_result; m_write_due = 1'b1; end
               2: begin m_addr = instruction[3:2]; m_data = mov_value;  m_write_due = 1'b1; end
               3: begin m_addr = instruction[3:2]; m_loading = 1'b1; m_waited = 0; end
               default: begin end
            endcase
         end
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      if (rf_we === 1'b1) dut_writes++;
      if (cmp_en) begin
         check("model_instr_ready", instr_ready, !(m_write_due || m_loading));
         check("model_mem_req", mem_req, m_loading);
         check("model_rf_we", rf_we, m_write_due);
         if (m_write_due) begin
            check("model_rf_waddr", rf_waddr, m_addr);
            check("model_rf_wdata", rf_wdata, m_data);
         end
`ifdef WB_MEM_TIMEOUT_EN
         check("model_mem_timeout", mem_timeout, m_timeout);
`endif
      end
   end

   logic [3:0] nw_ops [3];
   int         w0;

   initial begin
      nw_ops[0] = OP_STUR;
      nw_ops[1] = OP_CBZ;
      nw_ops[2] = 4'hF;

      // Reset state
      rst = 1'b1;
      step();
      step();
      check("reset_instr_ready", instr_ready, 1);
      check("reset_mem_req", mem_req, 0);
      check("reset_rf_we", rf_we, 0);
      check("reset_rf_wdata", rf_wdata, 8'h00);
      check("reset_rf_waddr", rf_waddr, 2'd0);
`ifdef WB_MEM_TIMEOUT_EN
      check("reset_mem_timeout", mem_timeout, 0);
`endif
      rst = 1'b0;
      cmp_en = 1'b1;

      // ALU write: ADD rd=2, data changes after accept
      instr_valid = 1'b1;
      instruction = mk(OP_ADD, 2'd2);
      alu_result  = 8'h5A;
      mov_value   = 8'hEE;
      check("alu_ready_at_n", instr_ready, 1);
      step();
      instr_valid = 1'b0;
      alu_result  = 8'h11;
      check("alu_rf_we_n1", rf_we, 1);
      check("alu_rf_waddr_n1", rf_waddr, 2'd2);
      check("alu_rf_wdata_n1", rf_wdata, 8'h5A);
      check("alu_ready_n1", instr_ready, 0);
      step();
      check("alu_ready_n2", instr_ready, 1);
      check("alu_rf_we_n2", rf_we, 0);

      // MOV write: MOV1 rd=3 takes mov_value
      instr_valid = 1'b1;
      instruction = mk(OP_MOV1, 2'd3);
      mov_value   = 8'h7E;
      alu_result  = 8'h00;
      step();
      instr_valid = 1'b0;
      check("mov_rf_we", rf_we, 1);
      check("mov_rf_waddr", rf_waddr, 2'd3);
      check("mov_rf_wdata", rf_wdata, 8'h7E);
      step();

      // Load with ack after 3 wait cycles
      w0 = dut_writes;
      instr_valid = 1'b1;
      instruction = mk(OP_LDUR, 2'd1);
      step();
      instr_valid = 1'b0;
      check("ld_ready_n1", instr_ready, 0);
      for (int k = 1; k <= 3; k++) begin
         check("ld_mem_req_wait", mem_req, 1);
         check("ld_no_write_wait", rf_we, 0);
         if (k == 3) begin
            mem_ack   = 1'b1;
            mem_rdata = 8'hC3;
         end
         step();
      end
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      check("ld_rf_we_n4", rf_we, 1);
      check("ld_rf_waddr_n4", rf_waddr, 2'd1);
      check("ld_rf_wdata_n4", rf_wdata, 8'hC3);
      check("ld_mem_req_n4", mem_req, 0);
      step();
      check("ld_ready_n5", instr_ready, 1);
      check("ld_one_write", dut_writes - w0, 1);

      // Non-writing stream, back-to-back
      w0 = dut_writes;
      instr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         instruction = mk(nw_ops[i], 2'(i));
         check("nw_ready_each", instr_ready, 1);
         step();
      end
      instr_valid = 1'b0;
      check("nw_ready_after", instr_ready, 1);
      step();
      check("nw_no_writes", dut_writes - w0, 0);

      // Reset during MEM_WAIT with a simultaneous ack
      w0 = dut_writes;
      instr_valid = 1'b1;
      instruction = mk(OP_LDUR, 2'd3);
      step();
      instr_valid = 1'b0;
      step();
      rst       = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = 8'hFF;
      step();
      check("rstld_mem_req", mem_req, 0);
      check("rstld_rf_we", rf_we, 0);
      check("rstld_ready", instr_ready, 1);
      rst = 1'b0;
      step();
      check("rstld_ack_ignored", rf_we, 0);
      mem_ack = 1'b0;
      step();
      check("rstld_no_writes", dut_writes - w0, 0);

`ifdef WB_MEM_TIMEOUT_EN
      // Timeout with no ack
      w0 = dut_writes;
      instr_valid = 1'b1;
      instruction = mk(OP_LDUR, 2'd2);
      step();
      instr_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         check("to_mem_req_wait", mem_req, 1);
         check("to_no_pulse_wait", mem_timeout, 0);
         step();
      end
      check("to_pulse", mem_timeout, 1);
      check("to_ready", instr_ready, 1);
      check("to_mem_req_drop", mem_req, 0);
      check("to_rf_we", rf_we, 0);
      step();
      check("to_pulse_one_cycle", mem_timeout, 0);
      check("to_no_writes", dut_writes - w0, 0);

      // Ack on the 4th wait cycle wins
      instr_valid = 1'b1;
      instruction = mk(OP_LDUR, 2'd2);
      step();
      instr_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         if (k == 4) begin
            mem_ack   = 1'b1;
            mem_rdata = 8'h3C;
         end
         step();
      end
      mem_ack = 1'b0;
      check("toack_rf_we", rf_we, 1);
      check("toack_rf_wdata", rf_wdata, 8'h3C);
      check("toack_no_pulse", mem_timeout, 0);
      step();
      check("toack_no_pulse_after", mem_timeout, 0);
`endif

      // Randomized phase against the model
      for (int c = 0; c < 3000; c++) begin
         rst         = ($urandom_range(0, 99) == 0);
         instr_valid = ($urandom_range(0, 3) != 0);
         instruction = 8'($urandom);
         alu_result  = 8'($urandom);
         mov_value   = 8'($urandom);
         mem_ack     = ($urandom_range(0, 2) == 0);
         mem_rdata   = 8'($urandom);
         step();
      end
      rst = 1'b0;
      instr_valid = 1'b0;
      mem_ack = 1'b0;
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/register_writeback_controller.md
# register_writeback_controller

Sequencing controller for the register-file write-back path of the 8-bit core. It accepts one decoded instruction at a time and selects the write-back source (ALU, MOV or load data). For LDUR it runs a request/acknowledge handshake with data memory, then issues a single registered register-file write. It back-pressures the fetch/decode stage while an instruction is in flight.

## Interface
- MEM_TIMEOUT_CYCLES, 16: maximum cycles to wait for `mem_ack`. Used only when timeout is compiled in; legal range 1–255.
- clk  input  1  core clock; all logic is rising-edge.
- rst  input  1  reset; synchronous, active-high.
- instr_valid  input  1  decode presents an instruction.
- instr_ready  output  1  controller can accept an instruction.
- instruction  input  8  opcode in [7:4] (`opcode_pkg::opcode_t`); destination register in [3:2].
- alu_result  input  8  ALU output for the presented instruction.
- mov_value  input  8  MOV operand for the presented instruction.
- mem_req  output  1  data-memory read request.
- mem_ack  input  1  memory read-data-valid strobe.
- mem_rdata  input  8  memory read data; valid when `mem_ack`=1.
- rf_we  output  1  register-file write enable; one-cycle pulse.
- rf_waddr  output  2  destination register.
- rf_wdata  output  8  write data.
- mem_timeout  output  1  one-cycle pulse when a load is aborted. Exists only with `WB_MEM_TIMEOUT_EN`.

## Operation
- **Writing classes**
  - ALU class: ADD, ADDI, SUB, SUBI, AND, OR, XOR, NOT, LSL, LSR.
  - MOV class: MOV1, MOV2.
  - LOAD class: LDUR.
  - All other opcodes are non-writing.
- **FSM states:** IDLE, WB, MEM_WAIT, MEM_WB.
- **IDLE:** `instr_ready`=1. An accept is `instr_valid & instr_ready`.
  - ALU or MOV on accept: latch `alu_result` or `mov_value` into `wdata_q`, latch `instruction[3:2]` into `waddr_q`, go to WB.
  - LOAD on accept: latch the address, go to MEM_WAIT.
  - Non-writing on accept: retire immediately and stay in IDLE. No write occurs.
- **WB:** `rf_we`=1 for exactly one cycle, then IDLE.
- **MEM_WAIT:** `mem_req`=1.
  - On `mem_ack`=1: capture `mem_rdata` into `wdata_q`, go to MEM_WB. `mem_req` deasserts in the cycle after ack.
  - `mem_ack` outside MEM_WAIT is ignored.
- **MEM_WB:** `rf_we`=1 for one cycle, then IDLE.
- **Write port:** `rf_waddr`/`rf_wdata` are driven from `waddr_q`/`wdata_q` at all times. They are meaningful only while `rf_we`=1.
- **Ready:** `instr_ready`=1 only in IDLE. It is a Moore output with no combinational dependence on `instr_valid`.
- **Reset:** `rst` in any state, including mid-load, returns to IDLE next edge and discards any pending write. Reset values:
  - `instr_ready`=1 after reset.
  - `mem_req`=0, `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `mem_timeout`=0.
  - Timeout counter = 0.
- **Unknown opcode value** (outside `opcode_t`): treated as non-writing.

## Timing
- Cycle N = accept edge.
- **ALU/MOV:** `rf_we`=1 in cycle N+1, `instr_ready`=0 in N+1, next accept possible at N+2. Throughput is one instruction per 2 cycles.
- **Non-writing:** `instr_ready` stays 1, giving back-to-back accepts.
- **LOAD:**
  - `mem_req`=1 from N+1.
  - If `mem_ack` is sampled at edge M, `rf_we`=1 in M+1 and the next accept is possible at M+2.
  - Minimum latency is ack at N+1, write at N+2.
- **Ack with reset:** an ack in the same cycle as `rst`=1 is discarded.

## Configuration
- **`WB_MEM_TIMEOUT_EN` defined:**
  - An 8-bit counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle without `mem_ack`.
  - When it reaches MEM_TIMEOUT_CYCLES: no write, `mem_timeout`=1 for one cycle, `mem_req` drops, return to IDLE.
  - If `mem_ack` arrives in the same cycle the limit is reached, the ack wins: normal write-back, no timeout pulse.
- **Undefined:** MEM_WAIT waits indefinitely. The counter and the `mem_timeout` port are not present.

## Test plan
- **Reset state:** assert `rst` 2 cycles → `instr_ready`=1, `mem_req`=0, `rf_we`=0, `rf_wdata`=8'h00.
- **ALU write:** ADD, rd=2, `alu_result`=8'h5A; change `alu_result` after accept → `rf_we` pulse at N+1 with `rf_waddr`=2, `rf_wdata`=8'h5A; `instr_ready`=0 at N+1 and 1 at N+2.
- **Load with delayed ack:** LDUR, rd=1, `mem_ack` after 3 wait cycles with `mem_rdata`=8'hC3 → `mem_req` high N+1..N+3, `rf_we` at N+4 with addr 1 and data 8'hC3; exactly one write.
- **Non-writing stream:** 3 back-to-back non-writing opcodes with `instr_valid` held high → 3 accepts in 3 cycles, `rf_we` never asserted.
- **Reset mid-load:** `rst` during MEM_WAIT, then `mem_ack`=1 with 8'hFF → IDLE, no `rf_we`, `mem_req`=0 after reset.
- **Timeout** (`WB_MEM_TIMEOUT_EN`, MEM_TIMEOUT_CYCLES=4): LDUR with no ack → `mem_timeout` pulse after 4 MEM_WAIT cycles, no `rf_we`, `instr_ready`=1 next cycle. Repeat with ack on the 4th cycle → normal write, no timeout pulse.
